// File: rtl/relay_framer.sv
// relay_framer: frames demodulated bits with relay start/end markers, packs them into
// nibbles and serialises each nibble (start bit + 4 bits, MSB first) onto relay_out.
module relay_framer #(
  parameter int DIV        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic mode_reader,
  input  logic frame_active,
  input  logic bit_in,
  input  logic bit_valid,
  output logic relay_out,
  output logic busy,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic            fa_q, fa_prev_q, rise;
  logic [2:0]      state_q, state_d;
  logic            mode_q, mode_d;
  logic [1:0]      mk_q, mk_d;
  logic [2:0]      sh_q, sh_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [3:0]      pend_nib_q, pend_nib_d;
  logic            rise_pend_q, rise_pend_d;
  logic            overflow_q, overflow_d;
  logic            push, take_bit, nib_done, do_push, pop;
  logic [3:0]      push_nib, full_nib;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            empty, full;
  logic            ser_act_q, ser_act_d;
  logic [2:0]      idx_q, idx_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      ssh_q, ssh_d;
  logic            relay_q, relay_d;

  assign rise     = fa_q & ~fa_prev_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign full_nib = {sh_q, bit_in};
  // Bits of a pending re-triggered frame are collected while END finishes the old one.
  assign take_bit = bit_valid & fa_q &
                    (((state_q == S_IDLE) & rise) | (state_q == S_START) | (state_q == S_DATA) |
                     ((state_q == S_END) & (rise_pend_q | rise)));
  assign nib_done = take_bit & (cnt_q == 2'd3);
  assign do_push  = push & ~full;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mk_d        = mk_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_nib_d  = pend_nib_q;
    rise_pend_d = rise_pend_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_nib    = 4'h0;
    if (take_bit) begin
      sh_d  = {sh_q[1:0], bit_in};
      cnt_d = cnt_q + 2'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          mode_d     = mode_reader;
          overflow_d = 1'b0;
          push       = 1'b1;
          push_nib   = mode_reader ? 4'hC : 4'hF;
          mk_d       = 2'd1;
          state_d    = mode_reader ? S_START : S_DATA;
        end
      end
      S_START: begin
        push = 1'b1;
        if (mk_q == 2'd0) begin
          push_nib = mode_q ? 4'hC : 4'hF;
          mk_d     = 2'd1;
          state_d  = mode_q ? S_START : S_DATA;
        end else begin
          push_nib = 4'h0;
          mk_d     = 2'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (pend_q) begin
          push     = 1'b1;
          push_nib = pend_nib_q;
          pend_d   = 1'b0;
        end
        if (!fa_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (rise) rise_pend_d = 1'b1;
        if (pend_q) begin
          push     = 1'b1;
          push_nib = pend_nib_q;
          pend_d   = 1'b0;
        end else begin
          push = (cnt_q != 2'd0);
          case (cnt_q)
            2'd1:    push_nib = {sh_q[0], 3'b000};
            2'd2:    push_nib = {sh_q[1:0], 2'b00};
            default: push_nib = {sh_q[2:0], 1'b0};
          endcase
          cnt_d   = 2'd0;
          mk_d    = 2'd0;
          state_d = S_END;
        end
      end
      S_END: begin
        push     = 1'b1;
        push_nib = 4'h0;
        mk_d     = mk_q + 2'd1;
        if (mk_q == (mode_q ? 2'd3 : 2'd1)) begin
          mk_d = 2'd0;
          if (rise_pend_q | rise) begin
            rise_pend_d = 1'b0;
            mode_d      = mode_reader;
            overflow_d  = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rise) begin
          rise_pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A nibble completing outside DATA waits so it follows the marker nibbles.
    if (nib_done) begin
      if ((state_q == S_DATA) && !pend_q) begin
        push     = 1'b1;
        push_nib = full_nib;
      end else begin
        pend_d     = 1'b1;
        pend_nib_d = full_nib;
      end
    end
    if (push && full) overflow_d = 1'b1;
  end

  always_comb begin
    ser_act_d = ser_act_q;
    idx_d     = idx_q;
    div_d     = div_q;
    ssh_d     = ssh_q;
    relay_d   = relay_q;
    pop       = 1'b0;
    if (!ser_act_q) begin
      if (!empty) begin
        pop       = 1'b1;
        ser_act_d = 1'b1;
        idx_d     = 3'd0;
        div_d     = '0;
        ssh_d     = mem_q[rd_ptr_q[AW-1:0]];
        relay_d   = 1'b1;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (idx_q == 3'd4) begin
        idx_d = 3'd0;
        if (!empty) begin
          pop     = 1'b1;
          ssh_d   = mem_q[rd_ptr_q[AW-1:0]];
          relay_d = 1'b1;
        end else begin
          ser_act_d = 1'b0;
          relay_d   = 1'b0;
        end
      end else begin
        idx_d   = idx_q + 3'd1;
        relay_d = ssh_q[3];
        ssh_d   = {ssh_q[2:0], 1'b0};
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_nib;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fa_q        <= 1'b0;
      fa_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      mk_q        <= 2'd0;
      sh_q        <= 3'd0;
      cnt_q       <= 2'd0;
      pend_q      <= 1'b0;
      pend_nib_q  <= 4'h0;
      rise_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ser_act_q   <= 1'b0;
      idx_q       <= 3'd0;
      div_q       <= '0;
      ssh_q       <= 4'h0;
      relay_q     <= 1'b0;
    end else begin
      fa_q        <= frame_active;
      fa_prev_q   <= fa_q;
      state_q     <= state_d;
      mode_q      <= mode_d;
      mk_q        <= mk_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_nib_q  <= pend_nib_d;
      rise_pend_q <= rise_pend_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ser_act_q   <= ser_act_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      ssh_q       <= ssh_d;
      relay_q     <= relay_d;
    end
  end

  assign relay_out = relay_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE) | ~empty | ser_act_q;
endmodule

// File: tb/tb_relay_framer.sv
// Bench for relay_framer: directed frames on a DIV=16 and a DIV=1024 instance, with a
// line-decoding monitor per instance popping hand-computed nibbles from a scoreboard.
module tb_relay_framer;
  logic clk = 1'b0;
  logic reset;
  logic mode_a, fa_a, bit_a, bv_a, out_a, busy_a, ovf_a;
  logic mode_b, fa_b, bit_b, bv_b, out_b, busy_b, ovf_b;
  int   total = 0;
  int   bad   = 0;
  int   e;
  int   highs;
  bit   mon_en = 1'b1;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  relay_framer #(.DIV(16), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .reset(reset), .mode_reader(mode_a), .frame_active(fa_a),
    .bit_in(bit_a), .bit_valid(bv_a), .relay_out(out_a), .busy(busy_a), .overflow(ovf_a));

  relay_framer #(.DIV(1024), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .reset(reset), .mode_reader(mode_b), .frame_active(fa_b),
    .bit_in(bit_b), .bit_valid(bv_b), .relay_out(out_b), .busy(busy_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [3:0] nib);
    for (int i = 3; i >= 0; i--) begin
      bit_a = nib[i];
      bv_a  = 1'b1;
      tick(1);
      bv_a  = 1'b0;
      tick(3);
    end
  endtask

  task automatic send_b(input logic [3:0] nib);
    for (int i = 3; i >= 0; i--) begin
      bit_b = nib[i];
      bv_b  = 1'b1;
      tick(1);
      bv_b  = 1'b0;
      tick(3);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? out_b : out_a;
  endfunction

  task automatic wait_done(input bit sel, input int limit, input string name);
    int n = 0;
    while ((((sel ? q_b.size() : q_a.size()) != 0) || (sel ? busy_b : busy_a)) && n < limit) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= limit) begin
      bad++;
      $display("FAIL %s: drain timeout, %0d nibbles still expected, busy=%0b", name,
               sel ? q_b.size() : q_a.size(), sel ? busy_b : busy_a);
    end
    chk({name, "_line_idle"}, int'(line(sel)), 0);
  endtask

  // Decodes one nibble per start bit by sampling the middle of each line bit.
  task automatic mon_run(input bit sel, input int div);
    logic [3:0] nib;
    logic [3:0] exp_nib;
    logic       st;
    forever begin
      @(negedge clk);
      if (line(sel) === 1'b1) begin
        repeat (div / 2) @(negedge clk);
        st = line(sel);
        for (int i = 3; i >= 0; i--) begin
          repeat (div) @(negedge clk);
          nib[i] = line(sel);
        end
        repeat (div / 2 - 1) @(negedge clk);
        if (sel || mon_en) begin
          total++;
          if ((sel ? q_b.size() : q_a.size()) == 0) begin
            bad++;
            $display("FAIL nibble_%s: got %h, no nibble expected", sel ? "b" : "a", nib);
          end else begin
            if (sel) exp_nib = q_b.pop_front();
            else     exp_nib = q_a.pop_front();
            if (st !== 1'b1 || nib !== exp_nib) begin
              bad++;
              $display("FAIL nibble_%s: got start=%b data=%h, want start=1 data=%h",
                       sel ? "b" : "a", st, nib, exp_nib);
            end
          end
        end
      end
    end
  endtask

  initial mon_run(1'b0, 16);
  initial mon_run(1'b1, 1024);

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {mode_a, fa_a, bit_a, bv_a} = 4'b0;
    {mode_b, fa_b, bit_b, bv_b} = 4'b0;
    #1 reset = 1'b0;
    #2;
    chk("reset_relay_a", int'(out_a), 0);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_ovf_a", int'(ovf_a), 0);
    chk("reset_relay_b", int'(out_b), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    chk("reset_ovf_b", int'(ovf_b), 0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // Reader frame 1010_0011 with latency and line-timing checks
    foreach (q_a[i]) q_a.delete(i);
    q_a = '{4'hC, 4'h0, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    mode_a = 1'b1;
    fa_a   = 1'b1;
    fork
      begin
        e = 0;
        while (out_a !== 1'b1 && e < 10) begin
          tick(1);
          e++;
        end
        chk("latency_edges", e, 3);
        tick(15);
        chk("start_bit_held", int'(out_a), 1);
        tick(1);
        chk("c_bit3", int'(out_a), 1);
        tick(16);
        chk("c_bit2", int'(out_a), 1);
        tick(16);
        chk("c_bit1", int'(out_a), 0);
        tick(642 - 51);
        chk("busy_before_end", int'(busy_a), 1);
        tick(1);
        chk("line_low_after_640", int'(out_a), 0);
        tick(1);
        chk("busy_dropped", int'(busy_a), 0);
      end
      begin
        tick(4);
        send_a(4'hA);
        send_a(4'h3);
        fa_a = 1'b0;
      end
    join
    wait_done(1'b0, 2000, "reader");

    // Tag frame with a 2-bit partial nibble
    tick(5);
    q_a = '{4'hF, 4'hC, 4'h0, 4'h0};
    mode_a = 1'b0;
    fa_a   = 1'b1;
    tick(4);
    for (int i = 0; i < 2; i++) begin
      bit_a = 1'b1;
      bv_a  = 1'b1;
      tick(1);
      bv_a  = 1'b0;
      tick(3);
    end
    fa_a = 1'b0;
    wait_done(1'b0, 2000, "tag");
    chk("tag_ovf", int'(ovf_a), 0);

    // Re-trigger two clocks after the fall, landing in END
    tick(5);
    q_a = '{4'hC, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0,
            4'hC, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    mode_a = 1'b1;
    fa_a   = 1'b1;
    tick(100);
    send_a(4'h9);
    fa_a = 1'b0;
    tick(2);
    fa_a = 1'b1;
    tick(400);
    send_a(4'h6);
    fa_a = 1'b0;
    wait_done(1'b0, 3000, "retrigger");
    chk("retrigger_ovf", int'(ovf_a), 0);

    // Overflow on the slow instance: only C,0,1..7 fit
    q_b = '{4'hC, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    mode_b = 1'b1;
    fa_b   = 1'b1;
    tick(4);
    for (int n = 1; n <= 10; n++) send_b(4'(n));
    fa_b = 1'b0;
    tick(10);
    chk("ovf_set", int'(ovf_b), 1);
    wait_done(1'b1, 50000, "overflow");
    chk("ovf_sticky", int'(ovf_b), 1);
    q_b = '{4'hF, 4'h0, 4'h0};
    mode_b = 1'b0;
    fa_b   = 1'b1;
    tick(4);
    chk("ovf_cleared_on_start", int'(ovf_b), 0);
    fa_b = 1'b0;
    wait_done(1'b1, 20000, "overflow_next");

    // Async reset in the middle of an overflowing frame
    mon_en = 1'b0;
    mode_a = 1'b1;
    fa_a   = 1'b1;
    tick(4);
    for (int n = 0; n < 12; n++) send_a(4'h5);
    chk("pre_reset_ovf", int'(ovf_a), 1);
    chk("pre_reset_busy", int'(busy_a), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_reset_relay", int'(out_a), 0);
    chk("async_reset_busy", int'(busy_a), 0);
    chk("async_reset_ovf", int'(ovf_a), 0);
    fa_a = 1'b0;
    tick(2);
    reset = 1'b1;
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (out_a !== 1'b0 || busy_a !== 1'b0) highs++;
    end
    chk("idle_after_reset", highs, 0);
    q_a.delete();
    mon_en = 1'b1;

    // Tag frame after reset
    q_a = '{4'hF, 4'hB, 4'h0, 4'h0};
    mode_a = 1'b0;
    fa_a   = 1'b1;
    tick(4);
    send_a(4'hB);
    fa_a = 1'b0;
    wait_done(1'b0, 2000, "post_reset_tag");
    chk("post_reset_ovf", int'(ovf_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
